reg_write_sched: RTL

Write-port scheduler and pending-write scoreboard for the single-write-port register file. It shares that one write port between the in-order pipeline writeback (MEM stage) and a multi-cycle unit (divider / late load return) that completes out of order. It tracks which registers have an outstanding multi-cycle write and raises a decode stall when ID reads one. It sits between MEM, the multi-cycle unit and the register file write port, and its stall is ORed into the ID stall.

---
 rtl/reg_write_sched_if.sv | 39 +++
 rtl/reg_write_sched.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/reg_write_sched_if.sv
// Bus bundle for reg_write_sched: pipeline writeback, multi-cycle unit, ID reads and RF write port.
// "master" is the pipeline/multi-cycle side and "slave" is the scheduler.
interface reg_write_sched_if #(
  parameter int REG_NUM = 32,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32
);
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              wb_hold;
  logic              mc_issue;
  logic [ADDR_W-1:0] mc_issue_addr;
  logic              mc_valid;
  logic [ADDR_W-1:0] mc_addr;
  logic [DATA_W-1:0] mc_data;
  logic              mc_ready;
  logic              rd_en_l;
  logic              rd_en_r;
  logic [ADDR_W-1:0] rd_addr_l;
  logic [ADDR_W-1:0] rd_addr_r;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              sb_stall;
  logic [REG_NUM-1:0] pending;

  modport master (
    output wb_valid, wb_addr, wb_data, mc_issue, mc_issue_addr,
           mc_valid, mc_addr, mc_data, rd_en_l, rd_en_r, rd_addr_l, rd_addr_r,
    input  wb_hold, mc_ready, rf_we, rf_waddr, rf_wdata, sb_stall, pending
  );

  modport slave (
    input  wb_valid, wb_addr, wb_data, mc_issue, mc_issue_addr,
           mc_valid, mc_addr, mc_data, rd_en_l, rd_en_r, rd_addr_l, rd_addr_r,
    output wb_hold, mc_ready, rf_we, rf_waddr, rf_wdata, sb_stall, pending
  );
endinterface

// File: rtl/reg_write_sched.sv
// Single write-port scheduler between MEM writeback and an out-of-order multi-cycle unit,
// with a pending-write scoreboard feeding the ID stall. REG_WRITE_SCHED_STARVE_EN enables forced mc grants.
module reg_write_sched #(
  parameter int REG_NUM      = 32,
  parameter int ADDR_W       = 5,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  reg_write_sched_if.slave   bus
);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};

  logic               starved_s;
  logic               grant_mc_s;
  logic               grant_wb_s;
  logic               wb_hold_s;
  logic               wr_req_s;
  logic [ADDR_W-1:0]  wr_addr_s;
  logic [DATA_W-1:0]  wr_data_s;
  logic               rf_we_r;
  logic [ADDR_W-1:0]  rf_waddr_r;
  logic [DATA_W-1:0]  rf_wdata_r;
  logic [REG_NUM-1:0] pending_r;
  logic [REG_NUM-1:0] pending_nxt_s;
  logic               sb_stall_s;

`ifdef REG_WRITE_SCHED_STARVE_EN
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);
  logic [CNT_W-1:0] starve_cnt_r;

  // Cycles the current mc result has been refused, saturating at the limit
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_r <= {CNT_W{1'b0}};
    end else if (!bus.mc_valid || grant_mc_s) begin
      starve_cnt_r <= {CNT_W{1'b0}};
    end else if (starve_cnt_r != LIMIT_C) begin
      starve_cnt_r <= starve_cnt_r + CNT_W'(1);
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end

  assign starved_s = (starve_cnt_r == LIMIT_C);
`else
  assign starved_s = 1'b0;
`endif

  // Port arbitration: wb wins unless the mc result has been starved
  always_comb begin
    grant_mc_s = 1'b0;
    grant_wb_s = 1'b0;
    wb_hold_s  = 1'b0;
    if (rst) begin
      grant_mc_s = 1'b0;
      grant_wb_s = 1'b0;
      wb_hold_s  = 1'b0;
    end else begin
      grant_mc_s = bus.mc_valid & (~bus.wb_valid | starved_s);
      wb_hold_s  = grant_mc_s & bus.wb_valid;
      grant_wb_s = bus.wb_valid & ~wb_hold_s;
    end
  end

  // Select the granted request for the write port
  always_comb begin
    wr_req_s  = 1'b0;
    wr_addr_s = rf_waddr_r;
    wr_data_s = rf_wdata_r;
    if (grant_mc_s) begin
      wr_req_s  = 1'b1;
      wr_addr_s = bus.mc_addr;
      wr_data_s = bus.mc_data;
    end else if (grant_wb_s) begin
      wr_req_s  = 1'b1;
      wr_addr_s = bus.wb_addr;
      wr_data_s = bus.wb_data;
    end else begin
      wr_req_s  = 1'b0;
      wr_addr_s = rf_waddr_r;
      wr_data_s = rf_wdata_r;
    end
  end

  // Registered write port; writes to r0 are consumed without an enable
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we_r    <= 1'b0;
      rf_waddr_r <= {ADDR_W{1'b0}};
      rf_wdata_r <= {DATA_W{1'b0}};
    end else if (wr_req_s) begin
      rf_we_r    <= (wr_addr_s != ZERO_ADDR);
      rf_waddr_r <= wr_addr_s;
      rf_wdata_r <= wr_data_s;
    end else begin
      rf_we_r    <= 1'b0;
      rf_waddr_r <= rf_waddr_r;
      rf_wdata_r <= rf_wdata_r;
    end
  end

  // Scoreboard update; a same-cycle issue overrides the clear
  always_comb begin
    pending_nxt_s = pending_r;
    if (grant_mc_s) begin
      pending_nxt_s[bus.mc_addr] = 1'b0;
    end else begin
      pending_nxt_s = pending_r;
    end
    if (bus.mc_issue && (bus.mc_issue_addr != ZERO_ADDR)) begin
      pending_nxt_s[bus.mc_issue_addr] = 1'b1;
    end else begin
      pending_nxt_s[0] = 1'b0;
    end
    pending_nxt_s[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_r <= {REG_NUM{1'b0}};
    end else begin
      pending_r <= pending_nxt_s;
    end
  end

  // ID stall when either read port touches a register with a write in flight
  always_comb begin
    sb_stall_s = (bus.rd_en_l & pending_r[bus.rd_addr_l] & (bus.rd_addr_l != ZERO_ADDR))
               | (bus.rd_en_r & pending_r[bus.rd_addr_r] & (bus.rd_addr_r != ZERO_ADDR));
  end

  assign bus.mc_ready = grant_mc_s;
  assign bus.wb_hold  = wb_hold_s;
  assign bus.rf_we    = rf_we_r;
  assign bus.rf_waddr = rf_waddr_r;
  assign bus.rf_wdata = rf_wdata_r;
  assign bus.sb_stall = sb_stall_s;
  assign bus.pending  = pending_r;
endmodule
